// File: rtl/svc_soc_io_init.sv
// MMIO initiator: turns valid/ready commands into single-cycle SoC I/O bus strobes and returns one response per command.
// Define SVC_SOC_IO_INIT_POLL_EN to enable POLL, which re-reads a register until a masked compare matches or a retry limit expires.
module svc_soc_io_init #(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [31:0]   cmd_addr,
  input  logic [31:0]   cmd_data,
  input  logic [31:0]   cmd_mask,
  input  logic [3:0]    cmd_strb,
  input  logic [PW-1:0] cfg_poll_limit,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_data,
  output logic          rsp_err,
  output logic          io_wen,
  output logic [31:0]   io_waddr,
  output logic [31:0]   io_wdata,
  output logic [3:0]    io_wstrb,
  output logic          io_ren,
  output logic [31:0]   io_raddr,
  input  logic [31:0]   io_rdata,
  output logic          busy
);

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_POLL  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_GAP,
    ST_RSP
  } state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  strb_q;
  logic        cmd_legal;

`ifdef SVC_SOC_IO_INIT_POLL_EN
  logic [31:0]   mask_q;
  logic [PW-1:0] limit_q;
  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_nxt;
  logic          poll_hit;

  assign cmd_legal = (cmd_op != 2'd3);
  assign cnt_nxt   = cnt_q + PW'(1);
  assign poll_hit  = ((io_rdata ^ data_q) & mask_q) == 32'd0;
`else
  logic unused_poll;

  // Without POLL support, op 2 takes the illegal-op path.
  assign cmd_legal   = (cmd_op == OP_WRITE) || (cmd_op == OP_READ);
  assign unused_poll = ^{cfg_poll_limit, cmd_mask};
`endif

  assign io_waddr = addr_q;
  assign io_raddr = addr_q;
  assign io_wdata = data_q;
  assign io_wstrb = strb_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_WRITE;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
      strb_q    <= 4'd0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_err   <= 1'b0;
      io_wen    <= 1'b0;
      io_ren    <= 1'b0;
`ifdef SVC_SOC_IO_INIT_POLL_EN
      mask_q    <= 32'd0;
      limit_q   <= PW'(1);
      cnt_q     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            addr_q    <= cmd_addr;
            data_q    <= cmd_data;
            strb_q    <= cmd_strb;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
`ifdef SVC_SOC_IO_INIT_POLL_EN
            mask_q    <= cmd_mask;
            limit_q   <= (cfg_poll_limit == '0) ? PW'(1) : cfg_poll_limit;
            cnt_q     <= '0;
`endif
            if (cmd_legal) begin
              state  <= ST_ACCESS;
              io_wen <= (cmd_op == OP_WRITE);
              io_ren <= (cmd_op != OP_WRITE);
            end else begin
              state     <= ST_RSP;
              rsp_valid <= 1'b1;
              rsp_data  <= 32'd0;
              rsp_err   <= 1'b1;
            end
          end
        end

        ST_ACCESS: begin
          io_wen    <= 1'b0;
          io_ren    <= 1'b0;
          state     <= ST_RSP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_data  <= (op_q == OP_WRITE) ? 32'd0 : io_rdata;
`ifdef SVC_SOC_IO_INIT_POLL_EN
          // The counter stops at the limit, so it never wraps.
          if (op_q == OP_POLL) begin
            cnt_q <= cnt_nxt;
            if (!poll_hit) begin
              if (cnt_nxt == limit_q) begin
                rsp_err <= 1'b1;
              end else begin
                state     <= ST_GAP;
                rsp_valid <= 1'b0;
              end
            end
          end
`endif
        end

`ifdef SVC_SOC_IO_INIT_POLL_EN
        ST_GAP: begin
          state  <= ST_ACCESS;
          io_ren <= 1'b1;
        end
`endif

        ST_RSP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          io_wen    <= 1'b0;
          io_ren    <= 1'b0;
        end
      endcase
    end
  end

endmodule
